// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - op codes, FSM states and sizing helper shared by the iterative MDU
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_DIV    = 2'd2,
    ST_FINISH = 2'd3
  } md_state_e;

  // Counter must be able to hold 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// rtl/md_iter_core.sv - one-bit-per-cycle shift-add multiply / restoring divide datapath
module md_iter_core
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   init,
  input  logic [WIDTH-1:0]   opnd_in,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_n;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        acc_n = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_n = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      opnd <= '0;
      cnt  <= '0;
    end else if (load) begin
      acc  <= {{WIDTH{1'b0}}, init};
      opnd <= opnd_in;
      cnt  <= '0;
    end else if (step) begin
      acc  <= acc_n;
      cnt  <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/iter_mdu.sv
// rtl/iter_mdu.sv - iterative multiply/divide unit with HI/LO, sign fix-up and accumulate
module iter_mdu
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             req,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [3:0]       md_type,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] md_out
);

  md_state_e state, state_n;

  logic               accept, load, step, commit;
  logic               is_mul, is_div, is_signed;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   hi, lo;
  logic [3:0]         op_q;
  logic               neg_q, neg_r, div0_q;
  logic [WIDTH-1:0]   rs_q;
  logic [2*WIDTH-1:0] core_acc;
  logic               core_last;
  logic [2*WIDTH-1:0] prod, mul_res;
  logic [WIDTH-1:0]   quo, rem, div_lo, div_hi;
  logic               op_is_div;

  always_comb begin
    is_mul    = md_type inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    is_div    = md_type inside {OP_DIV, OP_DIVU};
    is_signed = md_type inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    sign_a    = is_signed & rs[WIDTH-1];
    sign_b    = is_signed & rt[WIDTH-1];
    mag_a     = sign_a ? -rs : rs;
    mag_b     = sign_b ? -rt : rt;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    accept  = start && !req && (state == ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load = is_mul | is_div;
          if (is_mul) begin
            state_n = ST_MUL;
          end else if (is_div) begin
            state_n = ST_DIV;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (!req) begin
          step = 1'b1;
          if (core_last) begin
            state_n = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        if (!req) begin
          commit  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  assign busy = (state != ST_IDLE);

  md_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .div_mode(state == ST_DIV),
    .init    (is_div ? mag_a : mag_b),
    .opnd_in (is_div ? mag_b : mag_a),
    .acc     (core_acc),
    .last    (core_last)
  );

  // Most-negative / -1 needs no special case: the magnitude quotient is
  // 2^(WIDTH-1), signs match so it is not negated, and the remainder is 0.
  always_comb begin
    prod = neg_q ? -core_acc : core_acc;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {hi, lo} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {hi, lo} - prod;
      default:           mul_res = prod;
    endcase
    quo       = core_acc[WIDTH-1:0];
    rem       = core_acc[2*WIDTH-1:WIDTH];
    div_lo    = div0_q ? '1   : (neg_q ? -quo : quo);
    div_hi    = div0_q ? rs_q : (neg_r ? -rem : rem);
    op_is_div = op_q inside {OP_DIV, OP_DIVU};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0_q <= 1'b0;
      rs_q   <= '0;
    end else begin
      done <= commit;
      if (load) begin
        op_q   <= md_type;
        neg_q  <= sign_a ^ sign_b;
        neg_r  <= sign_a;
        div0_q <= (rt == '0);
        rs_q   <= rs;
      end
      if (accept && md_type == OP_MTHI) begin
        hi <= rs;
      end
      if (accept && md_type == OP_MTLO) begin
        lo <= rs;
      end
      if (commit) begin
        if (op_is_div) begin
          hi <= div_hi;
          lo <= div_lo;
        end else begin
          {hi, lo} <= mul_res;
        end
      end
    end
  end

  always_comb begin
    md_out = '0;
    if (md_type == OP_MFHI) begin
      md_out = hi;
    end else if (md_type == OP_MFLO) begin
      md_out = lo;
    end
  end

endmodule

// File: tb/tb_iter_mdu.sv
// tb/tb_iter_mdu.sv - scoreboard bench for iter_mdu against an arithmetic reference model
module tb_iter_mdu;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         req = 1'b0;
  logic [W-1:0] rs = '0;
  logic [W-1:0] rt = '0;
  logic [3:0]   md_type = '0;
  logic         busy, done;
  logic [W-1:0] md_out;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] rd_q[$];
  int           len_q[$];
  int           busy_run = 0;

  iter_mdu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .req    (req),
    .rs     (rs),
    .rt     (rt),
    .md_type(md_type),
    .busy   (busy),
    .done   (done),
    .md_out (md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: checks MF reads and busy-window length on every done pulse.
  always @(negedge clk) begin
    string nm;
    if (start && !req && (md_type == OP_MFHI || md_type == OP_MFLO)) begin
      nm = (md_type == OP_MFHI) ? "mfhi" : "mflo";
      if (rd_q.size() == 0) check("read_queue_nonempty", 0, 1);
      else check(nm, md_out, rd_q.pop_front());
    end
    if (done) begin
      if (len_q.size() == 0) check("done_queue_nonempty", 0, 1);
      else check("busy_cycles", busy_run, len_q.pop_front());
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] hl;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hl = {m_hi, m_lo};
    case (op)
      OP_MULT:  hl = 64'(sa * sb);
      OP_MULTU: hl = {32'b0, a} * {32'b0, b};
      OP_MADD:  hl = hl + 64'(sa * sb);
      OP_MADDU: hl = hl + {32'b0, a} * {32'b0, b};
      OP_MSUB:  hl = hl - 64'(sa * sb);
      OP_MSUBU: hl = hl - {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 0) hl = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) hl = {32'h0, 32'h8000_0000};
        else begin
          hl[31:0]  = 32'(sa / sb);
          hl[63:32] = 32'(sa % sb);
        end
      end
      OP_DIVU: begin
        if (b == 0) hl = {a, 32'hFFFF_FFFF};
        else hl = {a % b, a / b};
      end
      default: ;
    endcase
    {m_hi, m_lo} = hl;
  endtask

  task automatic read_back();
    start = 1'b1;
    md_type = OP_MFHI;
    rd_q.push_back(m_hi);
    tick();
    md_type = OP_MFLO;
    rd_q.push_back(m_lo);
    tick();
    start = 1'b0;
    md_type = OP_NONE;
  endtask

  task automatic mt(input logic [3:0] op, input logic [W-1:0] v);
    start = 1'b1;
    md_type = op;
    rs = v;
    tick();
    start = 1'b0;
    md_type = OP_NONE;
    if (op == OP_MTHI) m_hi = v;
    else m_lo = v;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int req_at, input int req_len, input bit mt_busy);
    bit seen;
    seen = 1'b0;
    model(op, a, b);
    len_q.push_back(W + 1 + req_len);
    start = 1'b1;
    md_type = op;
    rs = a;
    rt = b;
    tick();
    start = 1'b0;
    md_type = OP_NONE;
    for (int n = 0; n < 300 && !seen; n++) begin
      if (req_len > 0 && n == req_at) req = 1'b1;
      if (req_len > 0 && n == req_at + req_len) req = 1'b0;
      if (mt_busy && n == 2) begin
        start = 1'b1;
        md_type = OP_MTHI;
        rs = $urandom;
      end
      if (mt_busy && n == 3) begin
        start = 1'b0;
        md_type = OP_NONE;
      end
      tick();
      if (done) seen = 1'b1;
    end
    req = 1'b0;
    check("done_within_budget", seen, 1);
    read_back();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    md_type = OP_MFHI;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_md_out", md_out, 0);
    md_type = OP_NONE;
    reset = 1'b1;
    tick();
    read_back();

    mt(OP_MTLO, 32'hFFFF_FFFF);
    run_op(OP_MADDU, 32'd1, 32'd1, 0, 0, 1'b0);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b0);
    run_op(OP_MULTU, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
    run_op(OP_DIVU, 32'd7, 32'd0, 0, 0, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 0, 0, 1'b0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
    run_op(OP_MULT, 32'h0001_2345, 32'hFFFF_5678, 5, 10, 1'b1);
    run_op(OP_MSUB, 32'h7654_3210, 32'h8000_0001, W, 3, 1'b0);

    for (int i = 0; i < 16; i++) begin
      int           r;
      logic [3:0]   op;
      logic [W-1:0] a, b;
      int           rl;
      r  = $urandom_range(0, 7);
      op = (r < 4) ? 4'(r + 1) : 4'(r + 5);
      a  = $urandom >> $urandom_range(0, 28);
      b  = ($urandom_range(0, 5) == 0) ? '0 : ($urandom >> $urandom_range(0, 28));
      rl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      if (i % 4 == 0) mt(OP_MTHI, $urandom);
      run_op(op, a, b, $urandom_range(0, W), rl, 1'($urandom_range(0, 1)));
    end

    mt(OP_MTHI, 32'hCAFE_0001);
    mt(OP_MTLO, 32'hBEEF_0002);
    start = 1'b1;
    md_type = OP_MULT;
    rs = 32'h0000_1234;
    rt = 32'h0000_5678;
    tick();
    start = 1'b0;
    md_type = OP_NONE;
    repeat (11) tick();
    reset = 1'b0;
    #1;
    check("busy_after_async_reset", busy, 0);
    md_type = OP_MFLO;
    #1;
    check("mflo_after_async_reset", md_out, 0);
    md_type = OP_MFHI;
    #1;
    check("mfhi_after_async_reset", md_out, 0);
    md_type = OP_NONE;
    m_hi = '0;
    m_lo = '0;
    tick();
    reset = 1'b1;
    tick();
    read_back();

    repeat (3) tick();
    check("scoreboard_drained", rd_q.size() + len_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
